// File: rtl/alu4_driver.sv
// alu4_driver
//    Sequential initiator for a combinational alu4 datapath. A request
//    (ctl, in1, in2) is accepted when the driver is idle. The operands are
//    registered onto the ALU inputs and held for SETTLE cycles. The ALU
//    outputs are then captured and presented on a response handshake.
//
// Parameters
//    WIDTH   operand/result width (must match the attached ALU)
//    CTL_W   ALU op-select width
//    SETTLE  cycles operands are held before sampling, legal range 1..15
//
// Ports
//    clk, reset                      rising-edge clock, synchronous active-high reset
//    req_valid/req_ready             request handshake
//    req_ctl/req_in1/req_in2         request payload
//    alu_ctl/alu_in1/alu_in2         registered operands driven to the ALU
//    alu_out/alu_zf/alu_cf/alu_sf    ALU result and flags
//    rsp_valid/rsp_ready             response handshake
//    rsp_out/rsp_zf/rsp_cf/rsp_sf    captured result and flags
//    busy                            high while settling or holding a response
//
// Optional feature (macro ALU_DRV_CHECK_EN)
//    req_exp, req_exp_flags {zf,cf,sf}   expected result, latched with the request
//    rsp_mismatch                        captured {out,flags} differs from the expected value
//    err_count                           saturating count of mismatching responses
module alu4_driver #(
   parameter int WIDTH  = 4,
   parameter int CTL_W  = 2,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CTL_W-1:0] req_ctl,
   input  logic [WIDTH-1:0] req_in1,
   input  logic [WIDTH-1:0] req_in2,
   output logic [CTL_W-1:0] alu_ctl,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zf,
   input  logic             alu_cf,
   input  logic             alu_sf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_zf,
   output logic             rsp_cf,
   output logic             rsp_sf,
`ifdef ALU_DRV_CHECK_EN
   input  logic [WIDTH-1:0] req_exp,
   input  logic [2:0]       req_exp_flags,
   output logic             rsp_mismatch,
   output logic [7:0]       err_count,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // The counter counts down to zero, so it is loaded with SETTLE-1.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] cnt;

`ifdef ALU_DRV_CHECK_EN
   logic [WIDTH-1:0] exp_out;
   logic [2:0]       exp_flags;
`endif

   // Handshake status: ready only in IDLE and never while reset is asserted.
   always_comb begin
      req_ready = 1'b0;
      busy      = 1'b0;
      if (state == ST_IDLE) begin
         req_ready = !reset;
      end else begin
         busy = (state == ST_SETTLE) || (state == ST_RESP);
      end
   end

   // Control FSM with operand, capture and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         alu_ctl   <= '0;
         alu_in1   <= '0;
         alu_in2   <= '0;
         rsp_valid <= 1'b0;
         rsp_out   <= '0;
         rsp_zf    <= 1'b0;
         rsp_cf    <= 1'b0;
         rsp_sf    <= 1'b0;
`ifdef ALU_DRV_CHECK_EN
         exp_out      <= '0;
         exp_flags    <= 3'd0;
         rsp_mismatch <= 1'b0;
         err_count    <= 8'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  alu_ctl <= req_ctl;
                  alu_in1 <= req_in1;
                  alu_in2 <= req_in2;
`ifdef ALU_DRV_CHECK_EN
                  exp_out   <= req_exp;
                  exp_flags <= req_exp_flags;
`endif
                  cnt   <= CNT_LOAD;
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == 4'd0) begin
                  rsp_out   <= alu_out;
                  rsp_zf    <= alu_zf;
                  rsp_cf    <= alu_cf;
                  rsp_sf    <= alu_sf;
                  rsp_valid <= 1'b1;
`ifdef ALU_DRV_CHECK_EN
                  rsp_mismatch <= ({alu_out, alu_zf, alu_cf, alu_sf} != {exp_out, exp_flags});
`endif
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
`ifdef ALU_DRV_CHECK_EN
                  if (rsp_mismatch && (err_count != 8'hFF)) begin
                     err_count <= err_count + 8'd1;
                  end
`endif
                  state <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu4_driver.sv
// Directed testbench for alu4_driver: two instances (SETTLE=2 and SETTLE=1),
// each attached to a combinational alu4 model (0 add, 1 sub, 2 and, 3 or).
module tb_alu4_driver;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // alu4 model: returns {zf, cf, sf, out}
   function automatic logic [6:0] alu_f(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] t;
      case (c)
         2'd0:    t = {1'b0, a} + {1'b0, b};
         2'd1:    t = {1'b0, a} - {1'b0, b};
         2'd2:    t = {1'b0, a & b};
         default: t = {1'b0, a | b};
      endcase
      return {(t[3:0] == 4'd0), t[4], t[3], t[3:0]};
   endfunction

   // ---------------- instance 0, SETTLE=2 ----------------
   logic       req_valid = 1'b0, rsp_ready = 1'b0;
   logic [1:0] req_ctl = 2'd0;
   logic [3:0] req_in1 = 4'd0, req_in2 = 4'd0;
   logic       req_ready, rsp_valid, busy;
   logic [1:0] alu_ctl;
   logic [3:0] alu_in1, alu_in2, alu_out, rsp_out;
   logic       alu_zf, alu_cf, alu_sf, rsp_zf, rsp_cf, rsp_sf;
   assign {alu_zf, alu_cf, alu_sf, alu_out} = alu_f(alu_ctl, alu_in1, alu_in2);
`ifdef ALU_DRV_CHECK_EN
   logic [3:0] req_exp = 4'd0;
   logic [2:0] req_exp_flags = 3'd0;
   logic       rsp_mismatch;
   logic [7:0] err_count;
   logic [3:0] u1_exp = 4'd0;
   logic [2:0] u1_exp_flags = 3'd0;
   logic       u1_mismatch;
   logic [7:0] u1_err_count;
`endif

   alu4_driver #(.WIDTH(4), .CTL_W(2), .SETTLE(2)) u0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ctl(req_ctl), .req_in1(req_in1), .req_in2(req_in2),
      .alu_ctl(alu_ctl), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_sf(alu_sf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_zf(rsp_zf), .rsp_cf(rsp_cf), .rsp_sf(rsp_sf),
`ifdef ALU_DRV_CHECK_EN
      .req_exp(req_exp), .req_exp_flags(req_exp_flags),
      .rsp_mismatch(rsp_mismatch), .err_count(err_count),
`endif
      .busy(busy)
   );

   // ---------------- instance 1, SETTLE=1 ----------------
   logic       v1 = 1'b0, r1 = 1'b0;
   logic [1:0] c1 = 2'd0;
   logic [3:0] a1 = 4'd0, b1 = 4'd0;
   logic       rr1, rv1, busy1;
   logic [1:0] ac1;
   logic [3:0] ai1, bi1, ao1, ro1;
   logic       az1, acf1, as1, rz1, rc1, rs1;
   assign {az1, acf1, as1, ao1} = alu_f(ac1, ai1, bi1);

   alu4_driver #(.WIDTH(4), .CTL_W(2), .SETTLE(1)) u1 (
      .clk(clk), .reset(reset),
      .req_valid(v1), .req_ready(rr1),
      .req_ctl(c1), .req_in1(a1), .req_in2(b1),
      .alu_ctl(ac1), .alu_in1(ai1), .alu_in2(bi1),
      .alu_out(ao1), .alu_zf(az1), .alu_cf(acf1), .alu_sf(as1),
      .rsp_valid(rv1), .rsp_ready(r1),
      .rsp_out(ro1), .rsp_zf(rz1), .rsp_cf(rc1), .rsp_sf(rs1),
`ifdef ALU_DRV_CHECK_EN
      .req_exp(u1_exp), .req_exp_flags(u1_exp_flags),
      .rsp_mismatch(u1_mismatch), .err_count(u1_err_count),
`endif
      .busy(busy1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full operation on u0 with rsp_ready high; checks the captured result.
   task automatic op_chk(input string tag, input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] e_out, input logic [2:0] e_flags);
      int k;
      req_ctl = c; req_in1 = a; req_in2 = b; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      k = 0;
      while (!rsp_valid && k < 10) begin
         step();
         k++;
      end
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_out"}, 32'(rsp_out), 32'(e_out));
      chk({tag, "_flags"}, 32'({rsp_zf, rsp_cf, rsp_sf}), 32'(e_flags));
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      // reset
      step();
      step();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu", 32'({alu_ctl, alu_in1, alu_in2}), 32'd0);
      chk("rst_rsp", 32'({rsp_out, rsp_zf, rsp_cf, rsp_sf}), 32'd0);
      reset = 1'b0;
      #1;
      chk("idle_req_ready", 32'(req_ready), 32'd1);

      // 1: ctl=0 3+12 -> 15, sf=1
      req_ctl = 2'd0; req_in1 = 4'd3; req_in2 = 4'd12; req_valid = 1'b1;
`ifdef ALU_DRV_CHECK_EN
      req_exp = 4'd15; req_exp_flags = 3'b001;
`endif
      step();                                   // cycle 1
      req_valid = 1'b0;
      chk("t1_alu_in1", 32'(alu_in1), 32'd3);
      chk("t1_alu_in2", 32'(alu_in2), 32'd12);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_req_ready_c1", 32'(req_ready), 32'd0);
      chk("t1_rsp_valid_c1", 32'(rsp_valid), 32'd0);
      step();                                   // cycle 2
      chk("t1_rsp_valid_c2", 32'(rsp_valid), 32'd0);
      step();                                   // cycle 3
      chk("t1_rsp_valid_c3", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_out", 32'(rsp_out), 32'd15);
      chk("t1_rsp_flags", 32'({rsp_zf, rsp_cf, rsp_sf}), 32'b001);
`ifdef ALU_DRV_CHECK_EN
      chk("t5_match", 32'(rsp_mismatch), 32'd0);
`endif

      // 2: response stalled 5 cycles, held request waits for the handshake
      req_ctl = 2'd1; req_in1 = 4'd5; req_in2 = 4'd1; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("t2_rsp_out", 32'(rsp_out), 32'd15);
         chk("t2_req_ready", 32'(req_ready), 32'd0);
         chk("t2_alu_in1", 32'(alu_in1), 32'd3);
      end
      rsp_ready = 1'b1;
      chk("t2_hs_req_ready", 32'(req_ready), 32'd0);
      step();
      rsp_ready = 1'b0;
      chk("t2_after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t2_after_hs_req_ready", 32'(req_ready), 32'd1);
      chk("t2_not_in_hs", 32'(alu_in1), 32'd3);
      step();                                   // accepted: cycle 1 of new op
      req_valid = 1'b0;
      chk("t2_accept_alu", 32'({alu_ctl, alu_in1, alu_in2}), 32'({2'd1, 4'd5, 4'd1}));

      // 3: request pulsed during SETTLE is ignored
      req_in1 = 4'd7; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("t3_alu_in1", 32'(alu_in1), 32'd5);
      step();
      chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t3_rsp_out", 32'(rsp_out), 32'd4);
      chk("t3_rsp_flags", 32'({rsp_zf, rsp_cf, rsp_sf}), 32'b000);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("t3_done", 32'(rsp_valid), 32'd0);
      step();
      chk("t3_single_rsp", 32'(rsp_valid), 32'd0);
      chk("t3_idle_busy", 32'(busy), 32'd0);
      chk("t3_alu_hold", 32'(alu_in1), 32'd5);

      // 4: reset during SETTLE aborts the operation
      req_ctl = 2'd2; req_in1 = 4'd12; req_in2 = 4'd10; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("t4_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t4_alu", 32'({alu_ctl, alu_in1, alu_in2}), 32'd0);
      chk("t4_busy_rst", 32'(busy), 32'd0);
      reset = 1'b0;
      #1;
      chk("t4_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // further patterns: subtract with borrow, zero result
      op_chk("sub_borrow", 2'd1, 4'd2, 4'd5, 4'd13, 3'b011);
      op_chk("or_zero", 2'd3, 4'd0, 4'd0, 4'd0, 3'b100);
      op_chk("add_carry", 2'd0, 4'd9, 4'd9, 4'd2, 3'b010);

`ifdef ALU_DRV_CHECK_EN
      // 5: checker; the three ops above carried req_exp=15/001 and mismatched
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_err_rst", 32'(err_count), 32'd0);
      req_exp = 4'd14; req_exp_flags = 3'b001;
      req_ctl = 2'd0; req_in1 = 4'd3; req_in2 = 4'd12; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("t5_mismatch", 32'(rsp_mismatch), 32'd1);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("t5_err_one", 32'(err_count), 32'd1);
      for (int i = 0; i < 299; i++) begin
         op_chk("t5_loop", 2'd0, 4'd1, 4'd1, 4'd2, 3'b000);
      end
      chk("t5_err_sat", 32'(err_count), 32'd255);
`endif

      // 6: SETTLE=1 back-to-back, accept every 3 cycles
      a1 = 4'd1; b1 = 4'd2; c1 = 2'd0; r1 = 1'b1; v1 = 1'b1;
      chk("t6_ready_c0", 32'(rr1), 32'd1);
      for (int c = 1; c <= 9; c++) begin
         step();
         chk("t6_rsp_valid", 32'(rv1), 32'((c % 3) == 2));
         chk("t6_req_ready", 32'(rr1), 32'((c % 3) == 0));
         if ((c % 3) == 2) begin
            chk("t6_rsp_out", 32'(ro1), 32'd3);
         end
      end
      v1 = 1'b0;
      r1 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
